// File: rtl/sdp_arb_pkg.sv
// Shared constants and helpers for the simple-dual-port RAM port arbiter.
// Imported by the round-robin sub-arbiter and by the top level.
package sdp_arb_pkg;

  localparam int          MAX_REQ  = 4;
  localparam int          IDX_W    = $clog2(MAX_REQ);
  localparam logic [15:0] COLL_SAT = 16'hFFFF;

  function automatic logic [IDX_W-1:0] onehot_to_idx(input logic [MAX_REQ-1:0] oh);
    logic [IDX_W-1:0] idx;
    idx = '0;
    for (int i = 0; i < MAX_REQ; i++) begin
      if (oh[i]) idx = IDX_W'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/sdp_ram_port_arbiter_if.sv
// Requester-side bus of the RAM port arbiter: packed per-requester write/read
// requests, the one-hot grants, the tagged read return and the collision count.
interface sdp_ram_port_arbiter_if #(
  parameter int ADDR_W  = 10,
  parameter int DATA_W  = 36,
  parameter int NUM_REQ = 2
);

  // Handshake: a requester raises wr_req[i]/rd_req[i] and holds it, with a
  // stable address/data slice i, until the cycle wr_gnt[i]/rd_gnt[i] is high;
  // the transfer happens in exactly that cycle (req & gnt). Read data returns
  // on rd_data in the cycle rd_valid[i] is high, RD_LAT cycles after rd_gnt[i].
  logic [NUM_REQ-1:0]        wr_req;
  logic [NUM_REQ*ADDR_W-1:0] wr_addr;
  logic [NUM_REQ*DATA_W-1:0] wr_data;
  logic [NUM_REQ-1:0]        wr_gnt;
  logic [NUM_REQ-1:0]        rd_req;
  logic [NUM_REQ*ADDR_W-1:0] rd_addr;
  logic [NUM_REQ-1:0]        rd_gnt;
  logic [NUM_REQ-1:0]        rd_valid;
  logic [DATA_W-1:0]         rd_data;
  logic [15:0]               coll_cnt;

  modport master (
    output wr_req, wr_addr, wr_data, rd_req, rd_addr,
    input  wr_gnt, rd_gnt, rd_valid, rd_data, coll_cnt
  );

  modport slave (
    input  wr_req, wr_addr, wr_data, rd_req, rd_addr,
    output wr_gnt, rd_gnt, rd_valid, rd_data, coll_cnt
  );

endinterface

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter with a registered priority pointer.
// gnt is the winning candidate; the pointer moves past it only when advance is set.
module rr_arbiter
  import sdp_arb_pkg::*;
#(
  parameter int N = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] req,
  input  logic         advance,
  output logic [N-1:0] gnt
);

  localparam int PTR_W = (N > 1) ? $clog2(N) : 1;

  logic [PTR_W-1:0]   r_ptr;
  logic [PTR_W-1:0]   w_idx;
  logic               w_found;
  logic [MAX_REQ-1:0] w_gnt_ext;
  logic [IDX_W-1:0]   w_gnt_idx;
  logic [PTR_W-1:0]   w_ptr_nxt;

  // Search starts at the pointer and wraps modulo N; first requester wins.
  always_comb begin
    gnt     = '0;
    w_found = 1'b0;
    w_idx   = '0;
    for (int k = 0; k < N; k++) begin
      w_idx = PTR_W'((int'(r_ptr) + k) % N);
      if (!w_found && req[w_idx]) begin
        gnt[w_idx] = 1'b1;
        w_found    = 1'b1;
      end
    end
  end

  always_comb begin
    w_gnt_ext        = '0;
    w_gnt_ext[N-1:0] = gnt;
    w_gnt_idx        = onehot_to_idx(w_gnt_ext);
    w_ptr_nxt        = PTR_W'((int'(w_gnt_idx) + 1) % N);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ptr <= '0;
    end else if (advance) begin
      r_ptr <= w_ptr_nxt;
    end
  end

endmodule

// File: rtl/sdp_ram_port_arbiter.sv
// Shares one simple-dual-port RAM between NUM_REQ requesters: independent
// round-robin write/read arbitration, tagged read return, read-after-write deferral.
module sdp_ram_port_arbiter
  import sdp_arb_pkg::*;
#(
  parameter int ADDR_W  = 10,
  parameter int DATA_W  = 36,
  parameter int NUM_REQ = 2,
  parameter int RD_LAT  = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  sdp_ram_port_arbiter_if.slave bus,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_wr_addr,
  output logic [DATA_W-1:0] ram_din,
  output logic [ADDR_W-1:0] ram_rd_addr,
  input  logic [DATA_W-1:0] ram_dout
);

  logic [NUM_REQ-1:0] w_wr_cand;
  logic [NUM_REQ-1:0] w_rd_cand;
  logic [ADDR_W-1:0]  w_rd_cand_addr;
  logic               w_collide;
  logic               w_wr_adv;
  logic               w_rd_adv;
  logic [NUM_REQ-1:0] r_tag [RD_LAT];
  logic [15:0]        r_coll_cnt;

  rr_arbiter #(.N(NUM_REQ)) u_wr_arb (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     (bus.wr_req),
    .advance (w_wr_adv),
    .gnt     (w_wr_cand)
  );

  rr_arbiter #(.N(NUM_REQ)) u_rd_arb (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     (bus.rd_req),
    .advance (w_rd_adv),
    .gnt     (w_rd_cand)
  );

  assign bus.wr_gnt = w_wr_cand & {NUM_REQ{rst_n}};
  assign w_wr_adv   = |bus.wr_gnt;
  assign ram_we     = |bus.wr_gnt;

  always_comb begin
    ram_wr_addr    = '0;
    ram_din        = '0;
    w_rd_cand_addr = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (bus.wr_gnt[i]) begin
        ram_wr_addr = bus.wr_addr[i*ADDR_W +: ADDR_W];
        ram_din     = bus.wr_data[i*DATA_W +: DATA_W];
      end
      if (w_rd_cand[i]) w_rd_cand_addr = bus.rd_addr[i*ADDR_W +: ADDR_W];
    end
  end

  // A read hitting the address being written this cycle waits one cycle, so
  // it sees the new data instead of the RAM's undefined read-during-write value.
  assign w_collide   = ram_we && (|w_rd_cand) && (w_rd_cand_addr == ram_wr_addr);
  assign bus.rd_gnt  = w_collide ? '0 : (w_rd_cand & {NUM_REQ{rst_n}});
  assign w_rd_adv    = |bus.rd_gnt;
  assign ram_rd_addr = w_rd_adv ? w_rd_cand_addr : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < RD_LAT; k++) r_tag[k] <= '0;
      r_coll_cnt <= '0;
    end else begin
      r_tag[0] <= bus.rd_gnt;
      for (int k = 1; k < RD_LAT; k++) r_tag[k] <= r_tag[k-1];
      if (w_collide && (r_coll_cnt != COLL_SAT)) r_coll_cnt <= r_coll_cnt + 16'd1;
    end
  end

  assign bus.rd_valid = r_tag[RD_LAT-1];
  assign bus.rd_data  = ram_dout;
  assign bus.coll_cnt = r_coll_cnt;

endmodule

// File: tb/tb_sdp_ram_port_arbiter.sv
// Directed bench: one arbiter with RD_LAT=1 and one with RD_LAT=2, each
// attached to a behavioural registered-read RAM with matching latency.
module tb_sdp_ram_port_arbiter;

  localparam int AW = 10;
  localparam int DW = 36;
  localparam int NR = 2;

  logic clk;
  logic rst_n;

  int n_tests;
  int n_fail;

  logic [DW-1:0] exp_q[$];
  logic [NR-1:0] tag_q[$];
  logic [DW-1:0] sb_mem[512];

  sdp_ram_port_arbiter_if #(.ADDR_W(AW), .DATA_W(DW), .NUM_REQ(NR)) if1 ();
  sdp_ram_port_arbiter_if #(.ADDR_W(AW), .DATA_W(DW), .NUM_REQ(NR)) if2 ();

  logic          ram_we1, ram_we2;
  logic [AW-1:0] ram_wr_addr1, ram_wr_addr2, ram_rd_addr1, ram_rd_addr2;
  logic [DW-1:0] ram_din1, ram_din2, ram_dout1, ram_dout2, rq2;
  logic [DW-1:0] mem1[1024];
  logic [DW-1:0] mem2[1024];

  sdp_ram_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .NUM_REQ(NR), .RD_LAT(1)) dut1 (
    .clk         (clk),
    .rst_n       (rst_n),
    .bus         (if1),
    .ram_we      (ram_we1),
    .ram_wr_addr (ram_wr_addr1),
    .ram_din     (ram_din1),
    .ram_rd_addr (ram_rd_addr1),
    .ram_dout    (ram_dout1)
  );

  sdp_ram_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .NUM_REQ(NR), .RD_LAT(2)) dut2 (
    .clk         (clk),
    .rst_n       (rst_n),
    .bus         (if2),
    .ram_we      (ram_we2),
    .ram_wr_addr (ram_wr_addr2),
    .ram_din     (ram_din2),
    .ram_rd_addr (ram_rd_addr2),
    .ram_dout    (ram_dout2)
  );

  // ---------------- clock / reset / RAM models ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (ram_we1) mem1[ram_wr_addr1] <= ram_din1;
    ram_dout1 <= mem1[ram_rd_addr1];
  end

  always @(posedge clk) begin
    if (ram_we2) mem2[ram_wr_addr2] <= ram_din2;
    rq2       <= mem2[ram_rd_addr2];
    ram_dout2 <= rq2;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, got running exp finished");
    $fatal(1, "watchdog");
  end

  // ---------------- driver tasks ----------------
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    if1.wr_req = '0; if1.rd_req = '0; if1.wr_addr = '0; if1.wr_data = '0; if1.rd_addr = '0;
    if2.wr_req = '0; if2.rd_req = '0; if2.wr_addr = '0; if2.wr_data = '0; if2.rd_addr = '0;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst_n = 1'b0;
    next_cycle();
    next_cycle();
    rst_n = 1'b1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_n = 1'b0;
    clear_inputs();
    if1.wr_req = 2'b11; if1.rd_req = 2'b11;
    if2.wr_req = 2'b11; if2.rd_req = 2'b11;
    @(negedge clk);
    n_tests++; if (if1.wr_gnt !== 2'b00) begin n_fail++; $display("FAIL reset_wr_gnt got %b exp 00", if1.wr_gnt); end
    n_tests++; if (if1.rd_gnt !== 2'b00) begin n_fail++; $display("FAIL reset_rd_gnt got %b exp 00", if1.rd_gnt); end
    n_tests++; if (ram_we1 !== 1'b0) begin n_fail++; $display("FAIL reset_ram_we got %b exp 0", ram_we1); end
    n_tests++; if (if1.rd_valid !== 2'b00) begin n_fail++; $display("FAIL reset_rd_valid got %b exp 00", if1.rd_valid); end
    n_tests++; if (if1.coll_cnt !== 16'd0) begin n_fail++; $display("FAIL reset_coll_cnt got %0d exp 0", if1.coll_cnt); end
    n_tests++; if (if2.wr_gnt !== 2'b00) begin n_fail++; $display("FAIL reset_wr_gnt2 got %b exp 00", if2.wr_gnt); end
    next_cycle();
    clear_inputs();
    rst_n = 1'b1;
  endtask

  task automatic test_contention();
    logic [NR-1:0] eg;
    logic [AW-1:0] ea;
    logic [DW-1:0] ed;
    if1.wr_req  = 2'b11;
    if1.wr_addr = {10'h020, 10'h010};
    if1.wr_data = {36'h222222222, 36'h111111111};
    for (int k = 0; k < 4; k++) begin
      eg = (k % 2 == 0) ? 2'b01 : 2'b10;
      ea = (k % 2 == 0) ? 10'h010 : 10'h020;
      ed = (k % 2 == 0) ? 36'h111111111 : 36'h222222222;
      @(negedge clk);
      n_tests++; if (if1.wr_gnt !== eg) begin n_fail++; $display("FAIL contention_gnt[%0d] got %b exp %b", k, if1.wr_gnt, eg); end
      n_tests++; if (ram_we1 !== 1'b1) begin n_fail++; $display("FAIL contention_we[%0d] got %b exp 1", k, ram_we1); end
      n_tests++; if (ram_wr_addr1 !== ea) begin n_fail++; $display("FAIL contention_addr[%0d] got %h exp %h", k, ram_wr_addr1, ea); end
      n_tests++; if (ram_din1 !== ed) begin n_fail++; $display("FAIL contention_din[%0d] got %h exp %h", k, ram_din1, ed); end
      next_cycle();
    end
    clear_inputs();
  endtask

  task automatic test_single_write();
    if1.wr_req = 2'b01; if1.wr_addr[0 +: AW] = 10'h001; if1.wr_data[0 +: DW] = 36'h00000000F;
    @(negedge clk);
    n_tests++; if (if1.wr_gnt !== 2'b01) begin n_fail++; $display("FAIL single_wr_gnt got %b exp 01", if1.wr_gnt); end
    n_tests++; if (ram_wr_addr1 !== 10'h001) begin n_fail++; $display("FAIL single_wr_addr got %h exp 001", ram_wr_addr1); end
    n_tests++; if (ram_din1 !== 36'h00000000F) begin n_fail++; $display("FAIL single_wr_din got %h exp 00000000f", ram_din1); end
    next_cycle();
    clear_inputs();
    if1.rd_req = 2'b10; if1.rd_addr[AW +: AW] = 10'h001;
    @(negedge clk);
    n_tests++; if (if1.rd_gnt !== 2'b10) begin n_fail++; $display("FAIL single_rd_gnt got %b exp 10", if1.rd_gnt); end
    n_tests++; if (ram_rd_addr1 !== 10'h001) begin n_fail++; $display("FAIL single_rd_addr got %h exp 001", ram_rd_addr1); end
    n_tests++; if (if1.rd_valid !== 2'b00) begin n_fail++; $display("FAIL single_rd_early got %b exp 00", if1.rd_valid); end
    next_cycle();
    clear_inputs();
    @(negedge clk);
    n_tests++; if (if1.rd_valid !== 2'b10) begin n_fail++; $display("FAIL single_rd_valid got %b exp 10", if1.rd_valid); end
    n_tests++; if (if1.rd_data !== 36'h00000000F) begin n_fail++; $display("FAIL single_rd_data got %h exp 00000000f", if1.rd_data); end
    next_cycle();
    @(negedge clk);
    n_tests++; if (if1.rd_valid !== 2'b00) begin n_fail++; $display("FAIL single_rd_once got %b exp 00", if1.rd_valid); end
    next_cycle();
  endtask

  task automatic test_collision();
    if1.wr_req = 2'b01; if1.wr_addr[0 +: AW] = 10'h055; if1.wr_data[0 +: DW] = 36'hABCDE1234;
    if1.rd_req = 2'b10; if1.rd_addr[AW +: AW] = 10'h055;
    @(negedge clk);
    n_tests++; if (if1.wr_gnt !== 2'b01) begin n_fail++; $display("FAIL coll_wr_gnt got %b exp 01", if1.wr_gnt); end
    n_tests++; if (if1.rd_gnt !== 2'b00) begin n_fail++; $display("FAIL coll_rd_gnt got %b exp 00", if1.rd_gnt); end
    next_cycle();
    if1.wr_req = 2'b00;
    @(negedge clk);
    n_tests++; if (if1.coll_cnt !== 16'd1) begin n_fail++; $display("FAIL coll_cnt got %0d exp 1", if1.coll_cnt); end
    n_tests++; if (if1.rd_gnt !== 2'b10) begin n_fail++; $display("FAIL coll_retry_gnt got %b exp 10", if1.rd_gnt); end
    n_tests++; if (ram_rd_addr1 !== 10'h055) begin n_fail++; $display("FAIL coll_retry_addr got %h exp 055", ram_rd_addr1); end
    next_cycle();
    clear_inputs();
    @(negedge clk);
    n_tests++; if (if1.rd_valid !== 2'b10) begin n_fail++; $display("FAIL coll_rd_valid got %b exp 10", if1.rd_valid); end
    n_tests++; if (if1.rd_data !== 36'hABCDE1234) begin n_fail++; $display("FAIL coll_rd_data got %h exp abcde1234", if1.rd_data); end
    next_cycle();
  endtask

  task automatic test_same_requester();
    if1.wr_req = 2'b01; if1.wr_addr[0 +: AW] = 10'h056; if1.wr_data[0 +: DW] = 36'h123456789;
    if1.rd_req = 2'b01; if1.rd_addr[0 +: AW] = 10'h055;
    @(negedge clk);
    n_tests++; if (if1.wr_gnt !== 2'b01) begin n_fail++; $display("FAIL same_req_wr_gnt got %b exp 01", if1.wr_gnt); end
    n_tests++; if (if1.rd_gnt !== 2'b01) begin n_fail++; $display("FAIL same_req_rd_gnt got %b exp 01", if1.rd_gnt); end
    next_cycle();
    clear_inputs();
    @(negedge clk);
    n_tests++; if (if1.rd_valid !== 2'b01) begin n_fail++; $display("FAIL same_req_valid got %b exp 01", if1.rd_valid); end
    n_tests++; if (if1.rd_data !== 36'hABCDE1234) begin n_fail++; $display("FAIL same_req_data got %h exp abcde1234", if1.rd_data); end
    n_tests++; if (if1.coll_cnt !== 16'd1) begin n_fail++; $display("FAIL same_req_coll got %0d exp 1", if1.coll_cnt); end
    next_cycle();
  endtask

  task automatic test_sweep();
    logic [DW-1:0] d;
    logic [DW-1:0] ed;
    logic [NR-1:0] et;
    int r;
    do_reset();
    for (int i = 0; i < 512; i++) begin
      r = i % 2;
      d = {4'($urandom_range(15, 0)), 32'($urandom)};
      sb_mem[i] = d;
      clear_inputs();
      if1.wr_req = NR'(1 << r);
      if1.wr_addr[r*AW +: AW] = AW'(i);
      if1.wr_data[r*DW +: DW] = d;
      @(negedge clk);
      n_tests++; if (if1.wr_gnt !== NR'(1 << r)) begin n_fail++; $display("FAIL sweep_wr_gnt[%0d] got %b exp %b", i, if1.wr_gnt, NR'(1 << r)); end
      next_cycle();
    end
    for (int i = 0; i <= 512; i++) begin
      clear_inputs();
      r = i % 2;
      if (i < 512) begin
        if1.rd_req = NR'(1 << r);
        if1.rd_addr[r*AW +: AW] = AW'(i);
      end
      @(negedge clk);
      if (i > 0) begin
        ed = exp_q.pop_front();
        et = tag_q.pop_front();
        n_tests++; if (if1.rd_valid !== et) begin n_fail++; $display("FAIL sweep_valid[%0d] got %b exp %b", i - 1, if1.rd_valid, et); end
        n_tests++; if (if1.rd_data !== ed) begin n_fail++; $display("FAIL sweep_data[%0d] got %h exp %h", i - 1, if1.rd_data, ed); end
      end
      if (i < 512) begin
        n_tests++; if (if1.rd_gnt !== NR'(1 << r)) begin n_fail++; $display("FAIL sweep_rd_gnt[%0d] got %b exp %b", i, if1.rd_gnt, NR'(1 << r)); end
        exp_q.push_back(sb_mem[i]);
        tag_q.push_back(NR'(1 << r));
      end
      next_cycle();
    end
    n_tests++; if (if1.coll_cnt !== 16'd0) begin n_fail++; $display("FAIL sweep_coll_cnt got %0d exp 0", if1.coll_cnt); end
    clear_inputs();
  endtask

  task automatic test_back_to_back();
    logic [NR-1:0] eg;
    logic [DW-1:0] ed;
    for (int k = 0; k < 4; k++) begin
      clear_inputs();
      if2.wr_req = NR'(1 << (k % 2));
      if2.wr_addr[(k % 2)*AW +: AW] = AW'(10'h100 + k);
      if2.wr_data[(k % 2)*DW +: DW] = 36'h0CAFE0000 + DW'(k);
      next_cycle();
    end
    clear_inputs();
    for (int c = 0; c < 6; c++) begin
      if (c < 4) begin
        if2.rd_req  = 2'b11;
        if2.rd_addr = {10'h101, 10'h100};
      end else begin
        if2.rd_req = 2'b00;
      end
      @(negedge clk);
      if (c < 4) begin
        eg = (c % 2 == 0) ? 2'b01 : 2'b10;
        n_tests++; if (if2.rd_gnt !== eg) begin n_fail++; $display("FAIL b2b_gnt[%0d] got %b exp %b", c, if2.rd_gnt, eg); end
      end
      if (c < 2) begin
        n_tests++; if (if2.rd_valid !== 2'b00) begin n_fail++; $display("FAIL b2b_early[%0d] got %b exp 00", c, if2.rd_valid); end
      end else begin
        eg = (c % 2 == 0) ? 2'b01 : 2'b10;
        ed = (c % 2 == 0) ? 36'h0CAFE0000 : 36'h0CAFE0001;
        n_tests++; if (if2.rd_valid !== eg) begin n_fail++; $display("FAIL b2b_valid[%0d] got %b exp %b", c, if2.rd_valid, eg); end
        n_tests++; if (if2.rd_data !== ed) begin n_fail++; $display("FAIL b2b_data[%0d] got %h exp %h", c, if2.rd_data, ed); end
      end
      next_cycle();
    end
    clear_inputs();
  endtask

  task automatic test_reset_mid_read();
    if2.rd_req = 2'b01; if2.rd_addr[0 +: AW] = 10'h102;
    if2.wr_req = 2'b01; if2.wr_addr[0 +: AW] = 10'h104; if2.wr_data[0 +: DW] = 36'h000000104;
    @(negedge clk);
    n_tests++; if (if2.rd_gnt !== 2'b01) begin n_fail++; $display("FAIL mid_rst_gnt got %b exp 01", if2.rd_gnt); end
    next_cycle();
    clear_inputs();
    rst_n = 1'b0;
    for (int c = 0; c < 4; c++) begin
      if (c == 2) rst_n = 1'b1;
      @(negedge clk);
      n_tests++; if (if2.rd_valid !== 2'b00) begin n_fail++; $display("FAIL mid_rst_valid[%0d] got %b exp 00", c, if2.rd_valid); end
      next_cycle();
    end
    if2.wr_req  = 2'b11; if2.wr_addr = {10'h108, 10'h107};
    if2.rd_req  = 2'b11; if2.rd_addr = {10'h106, 10'h105};
    @(negedge clk);
    n_tests++; if (if2.rd_gnt !== 2'b01) begin n_fail++; $display("FAIL post_rst_rd_gnt got %b exp 01", if2.rd_gnt); end
    n_tests++; if (if2.wr_gnt !== 2'b01) begin n_fail++; $display("FAIL post_rst_wr_gnt got %b exp 01", if2.wr_gnt); end
    next_cycle();
    clear_inputs();
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    n_tests = 0;
    n_fail  = 0;
    test_reset();
    test_contention();
    test_single_write();
    test_collision();
    test_same_requester();
    test_sweep();
    test_back_to_back();
    test_reset_mid_read();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/sdp_ram_port_arbiter.md
Name: sdp_ram_port_arbiter

Overview:
- Shares one simple-dual-port RAM (1024x36 default, registered read, independent write and read ports) between NUM_REQ requesters.
- Arbitrates the write port and the read port independently, each with its own round-robin pointer.
- Returns read data tagged to the requester that issued the read.
- Defers a read that collides with a same-cycle write to the same address, so readers never observe an undefined read-during-write result.

Parameters:
- ADDR_W, 10, RAM address width (depth 2^ADDR_W).
- DATA_W, 36, RAM data width.
- NUM_REQ, 2, number of requesters; legal range 2..4.
- RD_LAT, 1, RAM read latency in clk cycles; legal range 1..2.

Ports:
- clk  in  1  single clock; all state on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- wr_req  in  NUM_REQ  per-requester write request; held until granted.
- wr_addr  in  NUM_REQ*ADDR_W  packed write addresses; requester i at slice i.
- wr_data  in  NUM_REQ*DATA_W  packed write data.
- wr_gnt  out  NUM_REQ  one-hot write grant; transfer occurs when wr_req[i] & wr_gnt[i].
- rd_req  in  NUM_REQ  per-requester read request; held until granted.
- rd_addr  in  NUM_REQ*ADDR_W  packed read addresses.
- rd_gnt  out  NUM_REQ  one-hot read grant.
- rd_valid  out  NUM_REQ  one-hot; rd_data belongs to the flagged requester.
- rd_data  out  DATA_W  read data, shared by all requesters.
- ram_we  out  1  RAM write enable.
- ram_wr_addr  out  ADDR_W  RAM write address.
- ram_din  out  DATA_W  RAM write data.
- ram_rd_addr  out  ADDR_W  RAM read address.
- ram_dout  in  DATA_W  RAM read data, valid RD_LAT cycles after the address.
- coll_cnt  out  16  saturating count of deferred (collided) reads.

Behaviour:
- Reset (rst_n low, asynchronous):
  - wr_ptr and rd_ptr = 0, so requester 0 has highest priority.
  - Tag pipeline cleared; rd_valid = 0; coll_cnt = 0.
  - wr_gnt, rd_gnt and ram_we forced 0 while rst_n is low.
- Grants are combinational in the same cycle as the request: zero-cycle grant, no bubbles.
- Round-robin:
  - Search begins at the pointer index and wraps modulo NUM_REQ.
  - After a transfer the pointer becomes (granted index + 1) mod NUM_REQ.
  - If no transfer occurs, the pointer is unchanged.
- Write path:
  - ram_we = |wr_gnt.
  - ram_wr_addr and ram_din = the granted slice; both 0 when nothing is granted.
- Read path:
  - ram_rd_addr = the granted slice; 0 when nothing is granted.
  - The one-hot tag (rd_gnt) enters an RD_LAT-deep shift register.
  - rd_valid = tag output; rd_data = ram_dout passed through unregistered.
  - Read latency from rd_gnt to rd_valid is exactly RD_LAT cycles.
- Collision rule:
  - Condition: a write is granted, the read candidate's address equals the granted write address, and this is the same cycle.
  - Response: rd_gnt is forced 0 that cycle, rd_ptr does not advance, and coll_cnt increments (saturating at 0xFFFF).
  - The next cycle the read proceeds and returns the newly written data.
- Same requester may be granted a write and a read in the same cycle (independent ports).
- Back-to-back reads are allowed: at most one rd_valid bit is asserted per cycle.
- Reset mid-operation:
  - In-flight read tags are discarded; no rd_valid is issued after reset for pre-reset reads.
  - Pointers return to 0.

Decomposition:
- Package sdp_arb_pkg holds:
  - MAX_REQ = 4.
  - The coll_cnt saturation constant.
  - A function for one-hot to index conversion.
- Sub-module rr_arbiter (parameter N; ports req, advance, gnt; owns the pointer) is instantiated twice, once for the write port and once for the read port.
- Collision compare and tag pipeline stay in the top level.

Test Plan:
- Single write: requester 0 writes addr 0x001 data 0x00000000F; then requester 1 reads 0x001 -> rd_valid = 2'b10 RD_LAT cycles after rd_gnt, rd_data = 0x00000000F.
- Contention: both requesters hold wr_req for 4 cycles, addresses 0x010/0x020 -> wr_gnt sequence 01,10,01,10; RAM receives alternating writes; no cycle without a grant.
- Collision: requester 0 writes 0x055 data 0xABCDE1234 while requester 1 reads 0x055 in the same cycle -> rd_gnt = 0 that cycle, coll_cnt = 1, read granted the next cycle, rd_data = 0xABCDE1234.
- Sweep: write addresses 0..511 with $random data via alternating requesters, then read all back -> every rd_data matches a scoreboard; coll_cnt = 0.
- Reset mid-read: assert rst_n low 1 cycle after rd_gnt with RD_LAT = 2 -> rd_valid never asserts; after reset requester 0 wins the first contended grant.
- RD_LAT = 2 back-to-back reads on alternating requesters -> rd_valid one-hot, same order as grants, exactly 2 cycles after each grant.
